// File: rtl/rgb_gray_pkg.sv
// rgb_gray_pkg: shared mode encoding and luma constants for the rgb_gray_pipe slice.
package rgb_gray_pkg;
  typedef enum logic [1:0] {MODE_PASS, MODE_LUMA, MODE_AVG, MODE_THRESH} mode_e;
  // BT.601 weights and half-LSB rounding term, scaled for 8 fractional bits
  localparam logic [7:0] KR    = 8'd77;
  localparam logic [7:0] KG    = 8'd150;
  localparam logic [7:0] KB    = 8'd29;
  localparam logic [7:0] ROUND = 8'd128;
endpackage

// File: rtl/rgb_gray_stage.sv
// rgb_gray_stage: stallable pipeline register carrying a valid bit and a payload.
module rgb_gray_stage #(
  parameter int W = 8
) (
  input  logic         iCLK,
  input  logic         iRST_n,
  input  logic         en_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);
  logic         valid_q;
  logic [W-1:0] data_q;
  always_ff @(posedge iCLK or negedge iRST_n)
    if (!iRST_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      data_q  <= data_i;
    end
  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/rgb_gray_pipe.sv
// rgb_gray_pipe: pipelined RGB-to-gray converter with valid/ready backpressure.
// Define RGB2GRAY_THRESH_EN to build the mode-3 binarisation comparator.
module rgb_gray_pipe
  import rgb_gray_pkg::*;
#(
  parameter int PIX_W  = 12,
  parameter int COEF_W = 8
) (
  input  logic             iCLK,
  input  logic             iRST_n,
  input  logic             iValid,
  output logic             oReady,
  input  logic [1:0]       iMode,
  input  logic [PIX_W-1:0] iThresh,
  input  logic [PIX_W-1:0] iRed,
  input  logic [PIX_W-1:0] iGreen,
  input  logic [PIX_W-1:0] iBlue,
  output logic             oValid,
  input  logic             iReady,
  output logic [PIX_W-1:0] oRed,
  output logic [PIX_W-1:0] oGreen,
  output logic [PIX_W-1:0] oBlue
);
  localparam int PW = PIX_W + COEF_W;
  localparam int SW = PW + 2;
  localparam int AW = PIX_W + 2;
  typedef struct packed {
    mode_e            mode;
`ifdef RGB2GRAY_THRESH_EN
    logic [PIX_W-1:0] thr;
`endif
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } hdr_t;
  typedef struct packed {
    hdr_t          h;
    logic [PW-1:0] pr;
    logic [PW-1:0] pg;
    logic [PW-1:0] pb;
    logic [AW-1:0] avg;
  } s2_t;
  typedef struct packed {
    hdr_t          h;
    logic [SW-1:0] sum;
    logic [AW-1:0] avg;
  } s3_t;
  logic               en, v1, v2, v3, oValid_q;
  hdr_t               s1_d, s1_q;
  s2_t                s2_d, s2_q;
  s3_t                s3_d, s3_q;
  logic [SW-1:0]      luma_full;
  logic [PIX_W-1:0]   luma, avg, gray;
  logic [3*PIX_W-1:0] out_d, out_q;
  assign en     = !oValid_q || iReady;
  assign oReady = en;
  always_comb begin
    s1_d.mode = mode_e'(iMode);
`ifdef RGB2GRAY_THRESH_EN
    s1_d.thr  = iThresh;
`endif
    s1_d.r    = iRed;
    s1_d.g    = iGreen;
    s1_d.b    = iBlue;
  end
  rgb_gray_stage #(.W($bits(hdr_t))) u_s1 (
    .iCLK(iCLK), .iRST_n(iRST_n), .en_i(en),
    .valid_i(iValid), .data_i(s1_d), .valid_o(v1), .data_o(s1_q)
  );
  assign s2_d = '{
    h:   s1_q,
    pr:  PW'(s1_q.r) * PW'(KR),
    pg:  PW'(s1_q.g) * PW'(KG),
    pb:  PW'(s1_q.b) * PW'(KB),
    avg: AW'(s1_q.r) + (AW'(s1_q.g) << 1) + AW'(s1_q.b)
  };
  rgb_gray_stage #(.W($bits(s2_t))) u_s2 (
    .iCLK(iCLK), .iRST_n(iRST_n), .en_i(en),
    .valid_i(v1), .data_i(s2_d), .valid_o(v2), .data_o(s2_q)
  );
  assign s3_d = '{
    h:   s2_q.h,
    sum: SW'(s2_q.pr) + SW'(s2_q.pg) + SW'(s2_q.pb),
    avg: s2_q.avg
  };
  rgb_gray_stage #(.W($bits(s3_t))) u_s3 (
    .iCLK(iCLK), .iRST_n(iRST_n), .en_i(en),
    .valid_i(v2), .data_i(s3_d), .valid_o(v3), .data_o(s3_q)
  );
  assign luma_full = (s3_q.sum + SW'(ROUND)) >> COEF_W;
  assign luma      = |luma_full[SW-1:PIX_W] ? '1 : luma_full[PIX_W-1:0];
  assign avg       = PIX_W'((s3_q.avg + AW'(2)) >> 2);
`ifdef RGB2GRAY_THRESH_EN
  assign gray = s3_q.h.mode == MODE_THRESH ? (luma >= s3_q.h.thr ? '1 : '0) :
                s3_q.h.mode == MODE_AVG    ? avg : luma;
`else
  logic unused_thresh;
  assign unused_thresh = ^iThresh;
  assign gray = s3_q.h.mode == MODE_AVG ? avg : luma;
`endif
  assign out_d = s3_q.h.mode == MODE_PASS ? {s3_q.h.r, s3_q.h.g, s3_q.h.b} : {3{gray}};
  always_ff @(posedge iCLK or negedge iRST_n)
    if (!iRST_n) begin
      oValid_q <= 1'b0;
      out_q    <= '0;
    end else if (en) begin
      oValid_q <= v3;
      out_q    <= out_d;
    end
  assign oValid               = oValid_q;
  assign {oRed, oGreen, oBlue} = out_q;
endmodule

// File: tb/tb_rgb_gray_pipe.sv
// tb_rgb_gray_pipe: randomized scoreboard bench for rgb_gray_pipe with directed corner pixels.
module tb_rgb_gray_pipe;
  localparam int PW = 12;
  logic          iCLK = 1'b0, iRST_n = 1'b1, iValid = 1'b0, iReady = 1'b0;
  logic          oReady, oValid;
  logic [1:0]    iMode = 2'd0;
  logic [PW-1:0] iThresh = '0, iRed = '0, iGreen = '0, iBlue = '0;
  logic [PW-1:0] oRed, oGreen, oBlue;
  int            tests = 0, fails = 0;
  logic [35:0]   q[$];

  always #5 iCLK = ~iCLK;

  rgb_gray_pipe dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iValid(iValid), .oReady(oReady),
    .iMode(iMode), .iThresh(iThresh), .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .oValid(oValid), .iReady(iReady), .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue)
  );

  task automatic check(input string n, input logic [35:0] a, input logic [35:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // Reference: spec arithmetic on plain integers.
  function automatic logic [35:0] model(input int m, input int r, input int g, input int b, input int t);
    int l, a, y;
    l = (77 * r + 150 * g + 29 * b + 128) / 256;
    if (l > 4095) l = 4095;
    a = (r + 2 * g + b + 2) / 4;
    if (m == 0) return {PW'(r), PW'(g), PW'(b)};
    y = (m == 2) ? a : l;
`ifdef RGB2GRAY_THRESH_EN
    if (m == 3) y = (l >= t) ? 4095 : 0;
`endif
    return {3{PW'(y)}};
  endfunction

  function automatic int rv();
    int s;
    s = $urandom_range(0, 7);
    return s == 0 ? 0 : s == 1 ? 4095 : int'($urandom_range(0, 4095));
  endfunction

  task automatic drive(input logic v, input int m, input int r, input int g, input int b,
                       input int t, input logic rdy, input logic [35:0] e, output logic acc);
    @(negedge iCLK);
    iValid = v; iMode = 2'(m); iRed = PW'(r); iGreen = PW'(g); iBlue = PW'(b);
    iThresh = PW'(t); iReady = rdy;
    #1;
    acc = v && oReady;
    if (acc) q.push_back(e);
  endtask

  task automatic idle();
    logic acc;
    drive(1'b0, 0, 0, 0, 0, 0, 1'b1, '0, acc);
  endtask

  task automatic send(input int m, input int r, input int g, input int b, input int t, input logic [35:0] e);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) drive(1'b1, m, r, g, b, t, 1'b1, e, acc);
    if (!acc) check("send_timeout", 36'(acc), 36'd1);
  endtask

  // Monitor: pops on every transfer and checks hold-stability under backpressure.
  initial begin
    logic        held;
    logic [35:0] hv;
    held = 1'b0;
    hv = '0;
    forever begin
      @(negedge iCLK);
      #2;
      if (!iRST_n) begin
        held = 1'b0;
        continue;
      end
      if (held) check("hold_stable", {oRed, oGreen, oBlue}, hv);
      held = oValid && !iReady;
      hv = {oRed, oGreen, oBlue};
      if (oValid && iReady) begin
        if (q.size() == 0) check("unexpected_pixel", 36'(oValid), 36'd0);
        else check("pixel", {oRed, oGreen, oBlue}, q.pop_front());
      end
    end
  end

  initial begin
    logic acc, pend;
    int   lat, k, pm, pr, pg, pb, pt;
    int   br[8], bg[8], bb[8], bm[8];
    #1 iRST_n = 1'b0;
    #11;
    check("rst_ovalid", 36'(oValid), 36'd0);
    check("rst_out", {oRed, oGreen, oBlue}, 36'd0);
    check("rst_oready", 36'(oReady), 36'd1);
    @(negedge iCLK);
    iRST_n = 1'b1;
    repeat (2) idle();
    // Latency with luma saturation pixel
    send(1, 4095, 4095, 4095, 0, {3{12'd4095}});
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      idle();
      if (oValid && lat == 0) lat = i;
    end
    check("latency", 36'(lat), 36'd4);
    send(1, 4095, 0, 0, 0, {3{12'd1232}});
    send(2, 100, 200, 300, 0, {3{12'd200}});
    for (int i = 0; i < 6; i++)
      send(i % 2, 10, 20, 30, 0, (i % 2 == 0) ? {12'd10, 12'd20, 12'd30} : {3{12'd18}});
`ifdef RGB2GRAY_THRESH_EN
    send(3, 4095, 0, 0, 1000, {3{12'd4095}});
    send(3, 4095, 0, 0, 1233, 36'd0);
`else
    send(3, 4095, 0, 0, 1000, {3{12'd1232}});
    send(3, 4095, 0, 0, 1233, {3{12'd1232}});
`endif
    repeat (8) idle();
    // Backpressure: 8-pixel stream with a 5-cycle downstream stall
    for (int i = 0; i < 8; i++) begin
      bm[i] = $urandom_range(0, 2); br[i] = rv(); bg[i] = rv(); bb[i] = rv();
    end
    k = 0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      drive(1'b1, bm[k], br[k], bg[k], bb[k], 0, !(c >= 5 && c < 10),
            model(bm[k], br[k], bg[k], bb[k], 0), acc);
      if (c >= 5 && c < 10) check("stall_oready", 36'(oReady), 36'd0);
      if (acc) k++;
    end
    check("bp_all_sent", 36'(k), 36'd8);
    repeat (8) idle();
    check("bp_drained", 36'(q.size()), 36'd0);
    // Reset with three pixels in flight
    for (int i = 0; i < 3; i++) send(1, 1000 + i, 500, 200, 0, model(1, 1000 + i, 500, 200, 0));
    #2;
    iRST_n = 1'b0;
    iValid = 1'b0;
    q.delete();
    #1;
    check("midrst_ovalid", 36'(oValid), 36'd0);
    check("midrst_out", {oRed, oGreen, oBlue}, 36'd0);
    check("midrst_oready", 36'(oReady), 36'd1);
    repeat (3) @(negedge iCLK);
    iRST_n = 1'b1;
    repeat (8) idle();
    // Randomized traffic with random backpressure
    pend = 1'b0;
    pm = 0; pr = 0; pg = 0; pb = 0; pt = 0;
    for (int c = 0; c < 600; c++) begin
      if (!pend) begin
        pend = $urandom_range(0, 4) != 0;
        pm = $urandom_range(0, 3); pr = rv(); pg = rv(); pb = rv(); pt = rv();
      end
      drive(pend, pm, pr, pg, pb, pt, $urandom_range(0, 3) != 0, model(pm, pr, pg, pb, pt), acc);
      if (acc) pend = 1'b0;
    end
    repeat (8) idle();
    check("final_drained", 36'(q.size()), 36'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
